// File: rtl/register_file_multiport_pkg.sv
//==============================================================================
// Module  : rf_pkg
// Brief   : Shared defaults, clear-FSM state encoding and flat-port helper
//           for the multiport register file.
// Revision: 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

package rf_pkg;

    localparam int RF_DATA_W = 32;
    localparam int RF_ADDR_W = 5;

    // Clear engine state: normal operation or sweeping the array to zero
    typedef enum logic [0:0] {
        RF_IDLE  = 1'b0,
        RF_CLEAR = 1'b1
    } rf_state_t;

    // Lowest bit of lane `port` in a flat bus made of `width`-bit lanes
    function automatic int flat_lsb(input int port, input int width);
        return port * width;
    endfunction

endpackage

`default_nettype wire

// File: rtl/register_file_multiport_if.sv
//==============================================================================
// Module  : register_file_multiport_if
// Brief   : Bus bundle between decode/writeback (master) and the register
//           file (slave).
// Revision: 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

interface register_file_multiport_if
    import rf_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int NUM_READ = 2
) ();

    logic                         write_enable;
    logic [ADDR_W-1:0]            write_target;
    logic [DATA_W-1:0]            write_data;
    logic [NUM_READ*ADDR_W-1:0]   read_source_flat;
    logic [NUM_READ*DATA_W-1:0]   read_port_flat;
    logic [NUM_READ-1:0]          read_pending_flat;
    logic                         pending_set;
    logic [ADDR_W-1:0]            pending_target;
    logic                         clear_request;
    logic                         busy;

    modport master (
        output write_enable, write_target, write_data, read_source_flat,
               pending_set, pending_target, clear_request,
        input  read_port_flat, read_pending_flat, busy
    );

    modport slave (
        input  write_enable, write_target, write_data, read_source_flat,
               pending_set, pending_target, clear_request,
        output read_port_flat, read_pending_flat, busy
    );

endinterface

`default_nettype wire

// File: rtl/register_file_multiport_scoreboard.sv
//==============================================================================
// Module  : rf_scoreboard
// Brief   : One pending bit per register. Writeback releases a bit, decode
//           sets it; a set on the same index as a release wins because it
//           names a newer producer.
// Revision: 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int ZERO_REG = 1
) (
    input  wire logic                   clk,
    input  wire logic                   rst_n,
    input  wire logic                   clear_all,
    input  wire logic                   release_en,
    input  wire logic [ADDR_W-1:0]      release_idx,
    input  wire logic                   set_en,
    input  wire logic [ADDR_W-1:0]      set_idx,
    output logic      [2**ADDR_W-1:0]   pending
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DEPTH-1:0] r_pending;
    logic [DEPTH-1:0] w_pending_next;

    // Release first, then set, so a same-index set overrides the release
    always_comb begin
        w_pending_next = r_pending;
        if (release_en) begin
            w_pending_next[release_idx] = 1'b0;
        end
        if (set_en) begin
            w_pending_next[set_idx] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            w_pending_next[0] = 1'b0;
        end
    end

    // Pending state; a clear sweep start wipes every outstanding producer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
        end else if (clear_all) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_next;
        end
    end

    assign pending = r_pending;

endmodule

`default_nettype wire

// File: rtl/register_file_multiport.sv
//==============================================================================
// Module  : register_file_multiport
// Brief   : Single-write, N-read register file with write-to-read bypass,
//           optional hardwired zero register, pending scoreboard and a
//           sequential clear engine.
// Revision: 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module register_file_multiport
    import rf_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int NUM_READ = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    register_file_multiport_if.slave   bus
);

    localparam int DEPTH = 2**ADDR_W;
    // Register 0 never needs sweeping when it is hardwired
    localparam logic [ADDR_W-1:0] c_first_idx = (ZERO_REG != 0) ? ADDR_W'(1) : '0;
    localparam logic [ADDR_W-1:0] c_last_idx  = ADDR_W'(DEPTH - 1);

    rf_state_t          r_state;
    logic [ADDR_W-1:0]  r_sweep_idx;
    logic               r_busy;
    logic [DATA_W-1:0]  r_regs [DEPTH];

    logic               w_write_accept;
    logic               w_set_accept;
    logic               w_clear_start;
    logic [DEPTH-1:0]   w_pending;

    assign w_write_accept = bus.write_enable && !r_busy &&
                            !((ZERO_REG != 0) && (bus.write_target == '0));
    assign w_set_accept   = bus.pending_set && !r_busy;
    assign w_clear_start  = (r_state == RF_IDLE) && bus.clear_request;
    assign bus.busy       = r_busy;

    // Clear engine: sweep index walks first..last, busy mirrors the state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= RF_CLEAR;
            r_sweep_idx <= c_first_idx;
            r_busy      <= 1'b1;
        end else begin
            case (r_state)
                RF_IDLE: begin
                    if (bus.clear_request) begin
                        r_state     <= RF_CLEAR;
                        r_sweep_idx <= c_first_idx;
                        r_busy      <= 1'b1;
                    end
                end
                RF_CLEAR: begin
                    if (r_sweep_idx == c_last_idx) begin
                        r_state <= RF_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_sweep_idx <= r_sweep_idx + ADDR_W'(1);
                    end
                end
                default: begin
                    r_state <= RF_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Storage: the sweep owns the write port while busy, otherwise writeback
    always_ff @(posedge clk) begin
        if (r_busy) begin
            r_regs[r_sweep_idx] <= '0;
        end else if (w_write_accept) begin
            r_regs[bus.write_target] <= bus.write_data;
        end
    end

    rf_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_all   (w_clear_start),
        .release_en  (w_write_accept),
        .release_idx (bus.write_target),
        .set_en      (w_set_accept),
        .set_idx     (bus.pending_target),
        .pending     (w_pending)
    );

    for (genvar k = 0; k < NUM_READ; k++) begin : g_read
        logic [ADDR_W-1:0] w_src;
        logic [DATA_W-1:0] w_data;

        assign w_src = bus.read_source_flat[flat_lsb(k, ADDR_W) +: ADDR_W];

        // Read mux: busy, then zero register, then bypass, then array
        always_comb begin
            w_data = r_regs[w_src];
            if (r_busy) begin
                w_data = '0;
            end else if ((ZERO_REG != 0) && (w_src == '0)) begin
                w_data = '0;
            end else if ((BYPASS != 0) && w_write_accept &&
                         (bus.write_target == w_src)) begin
                w_data = bus.write_data;
            end
        end

        assign bus.read_port_flat[flat_lsb(k, DATA_W) +: DATA_W] = w_data;
        // Pending view is the registered bit only; a same-cycle release is not forwarded
        assign bus.read_pending_flat[k] = !r_busy && w_pending[w_src];
    end

endmodule

`default_nettype wire

// File: tb/tb_register_file_multiport.sv
//==============================================================================
// Module  : tb_register_file_multiport
// Brief   : Directed self-checking bench for register_file_multiport
//           (default parameters: 32x32, two read ports, bypass, zero reg).
// Revision: 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_register_file_multiport;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    register_file_multiport_if #(.DATA_W(32), .ADDR_W(5), .NUM_READ(2)) bus ();

    register_file_multiport #(
        .DATA_W(32), .ADDR_W(5), .NUM_READ(2), .BYPASS(1), .ZERO_REG(1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.write_enable     = 1'b0;
        bus.write_target     = '0;
        bus.write_data       = '0;
        bus.read_source_flat = '0;
        bus.pending_set      = 1'b0;
        bus.pending_target   = '0;
        bus.clear_request    = 1'b0;
    endtask

    task automatic set_src(input int k, input logic [4:0] a);
        bus.read_source_flat[k*5 +: 5] = a;
    endtask

    function automatic logic [31:0] rd(input int k);
        return bus.read_port_flat[k*32 +: 32];
    endfunction

    task automatic fill_regs(input logic [31:0] base);
        for (int i = 1; i < 32; i++) begin
            bus.write_enable = 1'b1;
            bus.write_target = 5'(i);
            bus.write_data   = base | 32'(i);
            tick();
        end
        bus.write_enable = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < 32; i++) begin
            set_src(0, 5'(i));
            set_src(1, 5'(31 - i));
            #1;
            n_checks++;
            if (rd(0) !== 32'h0) begin
                n_fail++;
                $display("FAIL %s_port0 reg %0d: got %h expected 00000000", tag, i, rd(0));
            end
            n_checks++;
            if (rd(1) !== 32'h0) begin
                n_fail++;
                $display("FAIL %s_port1 reg %0d: got %h expected 00000000", tag, 31 - i, rd(1));
            end
            n_checks++;
            if (bus.read_pending_flat !== 2'b00) begin
                n_fail++;
                $display("FAIL %s_pending reg %0d: got %b expected 00", tag, i, bus.read_pending_flat);
            end
        end
    endtask

    task automatic count_busy(input string tag, input int expected);
        int cnt;
        cnt = 0;
        while (bus.busy === 1'b1 && cnt < 100) begin
            tick();
            cnt++;
        end
        n_checks++;
        if (cnt !== expected) begin
            n_fail++;
            $display("FAIL %s_busy_cycles: got %0d expected %0d", tag, cnt, expected);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        n_checks++;
        if (bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_busy: got %b expected 1", bus.busy);
        end
        n_checks++;
        if (bus.read_pending_flat !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_pending: got %b expected 00", bus.read_pending_flat);
        end
        rst_n = 1'b1;
        set_src(0, 5'd5);
        bus.write_enable = 1'b1;
        bus.write_target = 5'd5;
        bus.write_data   = 32'h1234_5678;
        #1;
        n_checks++;
        if (rd(0) !== 32'h0) begin
            n_fail++;
            $display("FAIL busy_read_zero: got %h expected 00000000", rd(0));
        end
        count_busy("reset", 31);
        bus.write_enable = 1'b0;
        #1;
        n_checks++;
        if (rd(0) !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_write_dropped: got %h expected 00000000", rd(0));
        end
    endtask

    task automatic test_bypass();
        idle_inputs();
        set_src(0, 5'd3);
        set_src(1, 5'd3);
        bus.write_enable = 1'b1;
        bus.write_target = 5'd3;
        bus.write_data   = 32'hDEAD_BEEF;
        #1;
        n_checks++;
        if (rd(0) !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL bypass_port0: got %h expected deadbeef", rd(0));
        end
        n_checks++;
        if (rd(1) !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL bypass_port1: got %h expected deadbeef", rd(1));
        end
        tick();
        bus.write_enable = 1'b0;
        set_src(1, 5'd4);
        #1;
        n_checks++;
        if (rd(0) !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL bypass_stored: got %h expected deadbeef", rd(0));
        end
        n_checks++;
        if (rd(1) !== 32'h0) begin
            n_fail++;
            $display("FAIL bypass_other_reg: got %h expected 00000000", rd(1));
        end
    endtask

    task automatic test_zero_reg();
        idle_inputs();
        set_src(0, 5'd0);
        bus.write_enable = 1'b1;
        bus.write_target = 5'd0;
        bus.write_data   = 32'hFFFF_FFFF;
        #1;
        n_checks++;
        if (rd(0) !== 32'h0) begin
            n_fail++;
            $display("FAIL zero_reg_no_bypass: got %h expected 00000000", rd(0));
        end
        tick();
        bus.write_enable   = 1'b0;
        bus.pending_set    = 1'b1;
        bus.pending_target = 5'd0;
        #1;
        n_checks++;
        if (rd(0) !== 32'h0) begin
            n_fail++;
            $display("FAIL zero_reg_write: got %h expected 00000000", rd(0));
        end
        tick();
        bus.pending_set = 1'b0;
        #1;
        n_checks++;
        if (bus.read_pending_flat[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_reg_pending: got %b expected 0", bus.read_pending_flat[0]);
        end
    endtask

    task automatic test_scoreboard();
        idle_inputs();
        set_src(0, 5'd7);
        set_src(1, 5'd8);
        bus.pending_set    = 1'b1;
        bus.pending_target = 5'd7;
        #1;
        n_checks++;
        if (bus.read_pending_flat[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL sb_set_not_early: got %b expected 0", bus.read_pending_flat[0]);
        end
        tick();
        bus.pending_set = 1'b0;
        #1;
        n_checks++;
        if (bus.read_pending_flat[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL sb_set: got %b expected 1", bus.read_pending_flat[0]);
        end
        bus.write_enable = 1'b1;
        bus.write_target = 5'd7;
        bus.write_data   = 32'h55;
        #1;
        n_checks++;
        if (bus.read_pending_flat[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL sb_no_pending_bypass: got %b expected 1", bus.read_pending_flat[0]);
        end
        n_checks++;
        if (rd(0) !== 32'h55) begin
            n_fail++;
            $display("FAIL sb_data_bypass: got %h expected 00000055", rd(0));
        end
        tick();
        bus.write_enable = 1'b0;
        #1;
        n_checks++;
        if (bus.read_pending_flat[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL sb_release: got %b expected 0", bus.read_pending_flat[0]);
        end
        // Write and set the same index: set wins
        bus.write_enable   = 1'b1;
        bus.write_target   = 5'd7;
        bus.write_data     = 32'h66;
        bus.pending_set    = 1'b1;
        bus.pending_target = 5'd7;
        tick();
        bus.write_enable = 1'b0;
        bus.pending_set  = 1'b0;
        #1;
        n_checks++;
        if (bus.read_pending_flat[0] !== 1'b1 || rd(0) !== 32'h66) begin
            n_fail++;
            $display("FAIL sb_set_wins: got pending %b data %h expected 1 00000066",
                     bus.read_pending_flat[0], rd(0));
        end
        // Write R7 and set R8 together: both take effect
        bus.write_enable   = 1'b1;
        bus.write_target   = 5'd7;
        bus.write_data     = 32'h77;
        bus.pending_set    = 1'b1;
        bus.pending_target = 5'd8;
        tick();
        bus.write_enable = 1'b0;
        bus.pending_set  = 1'b0;
        #1;
        n_checks++;
        if (bus.read_pending_flat !== 2'b10) begin
            n_fail++;
            $display("FAIL sb_split_indices: got %b expected 10", bus.read_pending_flat);
        end
    endtask

    task automatic test_clear_request();
        int cnt;
        idle_inputs();
        fill_regs(32'h0);
        bus.pending_set    = 1'b1;
        bus.pending_target = 5'd8;
        tick();
        bus.pending_set = 1'b0;
        set_src(0, 5'd17);
        set_src(1, 5'd8);
        #1;
        n_checks++;
        if (rd(0) !== 32'd17 || rd(1) !== 32'd8 || bus.read_pending_flat[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_prefill: got %h %h pend %b expected 00000011 00000008 pend 1",
                     rd(0), rd(1), bus.read_pending_flat[1]);
        end
        bus.clear_request = 1'b1;
        tick();
        bus.clear_request = 1'b0;
        n_checks++;
        if (bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_busy_start: got %b expected 1", bus.busy);
        end
        cnt = 0;
        while (bus.busy === 1'b1 && cnt < 100) begin
            bus.clear_request = (cnt == 15);
            tick();
            cnt++;
        end
        bus.clear_request = 1'b0;
        n_checks++;
        if (cnt !== 31) begin
            n_fail++;
            $display("FAIL clr_busy_cycles: got %0d expected 31", cnt);
        end
        check_all_zero("clr");
    endtask

    task automatic test_mid_sweep_reset();
        idle_inputs();
        fill_regs(32'hA500_0000);
        set_src(0, 5'd20);
        #1;
        n_checks++;
        if (rd(0) !== 32'hA500_0014) begin
            n_fail++;
            $display("FAIL msr_prefill: got %h expected a5000014", rd(0));
        end
        bus.clear_request = 1'b1;
        tick();
        bus.clear_request = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL msr_busy_in_reset: got %b expected 1", bus.busy);
        end
        tick();
        rst_n = 1'b1;
        count_busy("msr", 31);
        check_all_zero("msr");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_bypass();
        test_zero_reg();
        test_scoreboard();
        test_clear_request();
        test_mid_sweep_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/register_file_multiport.md
Name: register_file_multiport

Overview:
- Parametrised successor to the single-write, two-read core register file.
- Adds:
  - N combinational read ports.
  - Optional write-to-read bypass.
  - Optional hardwired zero register.
  - Per-register pending scoreboard for hazard tracking.
  - Sequential clear engine that sweeps the array to zero after reset or on request.
- Sits between decode (reads, pending checks) and writeback (writes, pending release).

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register index width; DEPTH = 2**ADDR_W (localparam).
- NUM_READ, 2, number of read ports (1..4).
- BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports.
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, is never pending.

Ports:
- Clock  in  1  system clock, rising edge.
- ResetN  in  1  asynchronous active-low reset.
- WriteEnable  in  1  write strobe.
- WriteTarget  in  ADDR_W  write index.
- WriteData  in  DATA_W  write value.
- ReadSourceFlat  in  NUM_READ*ADDR_W  read indices; port k = bits [k*ADDR_W +: ADDR_W].
- ReadPortFlat  out  NUM_READ*DATA_W  read data, same packing.
- ReadPendingFlat  out  NUM_READ  pending bit of each read source.
- PendingSet  in  1  mark PendingTarget as awaiting writeback.
- PendingTarget  in  ADDR_W  index to mark.
- ClearRequest  in  1  start a clear sweep.
- Busy  out  1  clear sweep in progress; writes and pending sets are ignored.

Behaviour:
- Reset (ResetN low, async):
  - FSM goes to CLEAR with sweep index = 0, or 1 if ZERO_REG.
  - All pending bits go to 0.
  - Busy = 1.
  - ReadPortFlat = 0 and ReadPendingFlat = 0 while Busy.
  - Array contents are not reset directly; the sweep zeroes them.
- FSM states:
  - IDLE:
    - ClearRequest=1 -> CLEAR next edge.
    - On that same edge, all pending bits clear.
    - A write on that same edge still commits, then is swept.
  - CLEAR:
    - Each edge writes 0 to Registers[index], then index++.
    - At index == DEPTH-1, write it and go to IDLE.
    - Sweep takes DEPTH cycles (DEPTH-1 with ZERO_REG).
    - ClearRequest is ignored in CLEAR.
- Busy = (state == CLEAR), registered. Deasserts in the cycle after the last swept register.
- Write: on a rising edge with WriteEnable=1 and Busy=0, Registers[WriteTarget] <= WriteData. Dropped if ZERO_REG and WriteTarget==0.
- Reads: combinational, zero-latency. ReadPort k = Registers[ReadSource k], with overrides in priority order:
  - Busy -> 0.
  - ZERO_REG and source==0 -> 0.
  - BYPASS and an accepted write to the same index this cycle -> WriteData.
- Multiple read ports may address the same index; each receives identical data.
- Pending scoreboard, DEPTH bits:
  - An accepted write to index i clears pending[i] at the edge.
  - PendingSet (Busy=0) sets pending[PendingTarget] at the edge.
  - Write and set to the same index in one cycle -> set wins (new producer).
  - Writes and sets to different indices in one cycle both take effect.
  - ZERO_REG: pending[0] is held at 0.
- ReadPendingFlat k = pending[ReadSource k], registered state with no bypass.
  - A same-cycle write does not clear the bit the reader sees; the data bypass still supplies the value.
- Reset asserted mid-sweep: the sweep restarts from the first index.

Decomposition:
- Shared package rf_pkg:
  - Default DATA_W / ADDR_W.
  - FSM state enum {RF_IDLE, RF_CLEAR}.
  - Helper function for flat-port slicing.
- Sub-module rf_scoreboard holds the pending-bit vector and its set/clear priority logic.
- Array, bypass muxes and clear FSM stay in the top module.

Test Plan:
- Reset release:
  - Busy=1 for 31 cycles (defaults).
  - Write R5=0x12345678 during Busy -> ignored.
  - After Busy falls, R5 reads 0x00000000.
- Bypass:
  - Same cycle: WriteEnable=1, WriteTarget=3, WriteData=0xDEADBEEF, port0 and port1 both read 3 -> both show 0xDEADBEEF.
  - Next cycle the read without a write still returns 0xDEADBEEF.
- Zero register:
  - Write R0=0xFFFFFFFF -> port reads 0.
  - PendingSet to R0 -> ReadPending=0.
- Scoreboard:
  - PendingSet R7 -> next cycle ReadPending=1.
  - Write R7=0x55 -> same cycle ReadPending still 1 and data 0x55; next cycle ReadPending=0.
  - Simultaneous write R7 and PendingSet R7 -> ReadPending=1 afterwards.
- ClearRequest:
  - Fill R1..R31 with index values, then pulse ClearRequest.
  - Busy for 31 cycles; a second ClearRequest mid-sweep has no effect.
  - Afterwards all registers read 0 and all pending bits are 0.
- Mid-sweep reset:
  - Assert ResetN=0 at sweep index 10, release.
  - Sweep restarts at 1, Busy held 31 further cycles, all registers 0.
